// File: rtl/mru_share_arbiter_pkg.sv
// mru_share_arbiter_pkg: shared state enum, default sizes and response record.
package mru_share_arbiter_pkg;

    typedef enum logic {RUN, FLUSH} state_t;

    localparam int NUM_REQ_D  = 4;
    localparam int DATA_W_D   = 8;
    localparam int DEPTH_D    = 4;
    localparam int RSP_ID_W   = $clog2(NUM_REQ_D);
    localparam int RSP_POS_W  = $clog2(DEPTH_D);
    localparam int RSP_DATA_W = DATA_W_D;

    typedef struct packed {
        logic [RSP_ID_W-1:0]   id;
        logic                  hit;
        logic [RSP_POS_W-1:0]  pos;
        logic                  evict_valid;
        logic [RSP_DATA_W-1:0] evict_data;
    } rsp_t;

endpackage

// File: rtl/mru_share_arbiter_if.sv
// mru_share_arbiter_if: requester handshake and tagged response bundle.
interface mru_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int POS_W = $clog2(DEPTH);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_hit;
    logic [POS_W-1:0]          rsp_pos;
    logic                      rsp_evict_valid;
    logic [DATA_W-1:0]         rsp_evict_data;

    modport slave (
        input  req_valid, req_data,
        output req_ready, rsp_valid, rsp_id, rsp_hit, rsp_pos, rsp_evict_valid, rsp_evict_data
    );

    modport master (
        output req_valid, req_data,
        input  req_ready, rsp_valid, rsp_id, rsp_hit, rsp_pos, rsp_evict_valid, rsp_evict_data
    );

endinterface

// File: rtl/mru_share_arbiter_list.sv
// mru_list_core: most-recently-used value list with move-to-front, insert/evict and per-entry clear.
module mru_list_core #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int POS_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_upd,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_clr,
    input  logic [POS_W-1:0]         i_clr_idx,
    output logic                     o_hit,
    output logic [POS_W-1:0]         o_pos,
    output logic                     o_evict_valid,
    output logic [DATA_W-1:0]        o_evict_data,
    output logic [DEPTH*DATA_W-1:0]  o_mru_data,
    output logic [DEPTH-1:0]         o_mru_valid
);
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  w_shift;

    // Entries are distinct, so at most one slot can match.
    always_comb begin
        o_hit = 1'b0;
        o_pos = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_valid[k] && r_data[k] == i_data) begin
                o_hit = 1'b1;
                o_pos = POS_W'(k);
            end
        end
    end

    always_comb begin
        w_shift = '0;
        for (int k = 1; k < DEPTH; k++)
            w_shift[k] = !o_hit || (POS_W'(k) <= o_pos);
    end

    assign o_evict_valid = !o_hit && r_valid[DEPTH-1];
    assign o_evict_data  = o_evict_valid ? r_data[DEPTH-1] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++)
                r_data[k] <= '0;
        end else if (i_clr) begin
            r_valid[i_clr_idx] <= 1'b0;
            r_data[i_clr_idx]  <= '0;
        end else if (i_upd) begin
            r_valid[0] <= 1'b1;
            r_data[0]  <= i_data;
            for (int k = 1; k < DEPTH; k++) begin
                if (w_shift[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    r_data[k]  <= r_data[k-1];
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign o_mru_data[g*DATA_W +: DATA_W] = r_data[g];
    end
    assign o_mru_valid = r_valid;

endmodule

// File: rtl/mru_share_arbiter.sv
// mru_share_arbiter: round-robin access to a shared MRU value list with registered responses and sequenced flush.
module mru_share_arbiter
    import mru_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int DEPTH   = DEPTH_D
) (
    input  logic                    clk,
    input  logic                    rst,
    mru_share_arbiter_if.slave      bus,
    input  logic                    i_flush,
    output logic                    o_flush_done,
    output logic                    o_busy,
    output logic [DEPTH*DATA_W-1:0] o_mru_data,
    output logic [DEPTH-1:0]        o_mru_valid
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int POS_W = $clog2(DEPTH);

    state_t             r_state, w_state_nxt;
    logic [POS_W-1:0]   r_cnt, w_cnt_nxt;
    logic [ID_W-1:0]    r_rr_ptr, w_gnt_id;
    logic               w_found, w_acc;
    logic [NUM_REQ-1:0] w_gnt;
    logic [DATA_W-1:0]  w_data;
    logic               w_hit;
    logic [POS_W-1:0]   w_pos;
    logic               w_ev_valid;
    logic [DATA_W-1:0]  w_ev_data;
    logic               r_rsp_valid;
    rsp_t               r_rsp;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = r_rr_ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!w_found && bus.req_valid[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_gnt_id = ID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_acc  = r_state == RUN && !i_flush && w_found;
    assign w_gnt  = w_acc ? NUM_REQ'(1) << w_gnt_id : '0;
    assign w_data = bus.req_data[w_gnt_id*DATA_W +: DATA_W];

    always_comb begin
        w_state_nxt = r_state == RUN ? (i_flush ? FLUSH : RUN) : (r_cnt == '0 ? RUN : FLUSH);
        w_cnt_nxt   = r_state == RUN ? POS_W'(DEPTH-1) : r_cnt - POS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= ID_W'(NUM_REQ-1);
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            r_rsp_valid <= w_acc;
            if (w_acc) begin
                r_rr_ptr <= w_gnt_id;
                r_rsp    <= '{id: RSP_ID_W'(w_gnt_id), hit: w_hit, pos: RSP_POS_W'(w_pos),
                              evict_valid: w_ev_valid, evict_data: RSP_DATA_W'(w_ev_data)};
            end
        end
    end

    mru_list_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .POS_W(POS_W)) u_list (
        .clk          (clk),
        .rst          (rst),
        .i_upd        (w_acc),
        .i_data       (w_data),
        .i_clr        (r_state == FLUSH),
        .i_clr_idx    (r_cnt),
        .o_hit        (w_hit),
        .o_pos        (w_pos),
        .o_evict_valid(w_ev_valid),
        .o_evict_data (w_ev_data),
        .o_mru_data   (o_mru_data),
        .o_mru_valid  (o_mru_valid)
    );

    assign bus.req_ready       = w_gnt;
    assign bus.rsp_valid       = r_rsp_valid;
    assign bus.rsp_id          = ID_W'(r_rsp.id);
    assign bus.rsp_hit         = r_rsp.hit;
    assign bus.rsp_pos         = POS_W'(r_rsp.pos);
    assign bus.rsp_evict_valid = r_rsp.evict_valid;
    assign bus.rsp_evict_data  = DATA_W'(r_rsp.evict_data);
    assign o_busy              = r_state == FLUSH;
    assign o_flush_done        = o_busy && r_cnt == '0;

endmodule

// File: tb/tb_mru_share_arbiter.sv
// tb_mru_share_arbiter: directed vectors with hand-computed expectations for mru_share_arbiter.
module tb_mru_share_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_flush = 1'b0;
    logic        o_flush_done, o_busy;
    logic [31:0] o_mru_data;
    logic [3:0]  o_mru_valid;
    int          n_vec = 0;
    int          n_err = 0;

    mru_share_arbiter_if #(.NUM_REQ(4), .DATA_W(8), .DEPTH(4)) bus ();

    mru_share_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .i_flush     (i_flush),
        .o_flush_done(o_flush_done),
        .o_busy      (o_busy),
        .o_mru_data  (o_mru_data),
        .o_mru_valid (o_mru_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_flush = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic send(input int id, input logic [7:0] d);
        bus.req_valid = 4'(1 << id);
        bus.req_data = '0;
        bus.req_data[id*8 +: 8] = d;
        #1;
        chk("ready", 32'(bus.req_ready), 32'(1 << id));
        cyc();
        bus.req_valid = '0;
    endtask

    task automatic chk_rsp(input int id, input bit hit, input int pos, input bit ev, input logic [7:0] evd);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_id", 32'(bus.rsp_id), 32'(id));
        chk("rsp_hit", 32'(bus.rsp_hit), 32'(hit));
        chk("rsp_pos", 32'(bus.rsp_pos), 32'(pos));
        chk("evict_valid", 32'(bus.rsp_evict_valid), 32'(ev));
        chk("evict_data", 32'(bus.rsp_evict_data), 32'(evd));
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data = '0;
        do_reset();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mru_valid", 32'(o_mru_valid), 32'd0);
        chk("rst_mru_data", o_mru_data, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_flush_done", 32'(o_flush_done), 32'd0);

        // zero into an empty list must miss
        send(0, 8'h00);
        chk_rsp(0, 0, 0, 0, 8'h00);
        chk("mv_first", 32'(o_mru_valid), 32'h1);
        chk("md_first", o_mru_data, 32'h0);
        cyc();
        chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        send(0, 8'h11);
        send(0, 8'h22);
        send(0, 8'h33);
        chk_rsp(0, 0, 0, 0, 8'h00);
        chk("md_full", o_mru_data, 32'h00112233);
        send(0, 8'h44);
        chk_rsp(0, 0, 0, 1, 8'h00);
        send(0, 8'h55);
        chk_rsp(0, 0, 0, 1, 8'h11);
        chk("md_evict", o_mru_data, 32'h22334455);
        chk("mv_evict", 32'(o_mru_valid), 32'hF);

        do_reset();
        send(0, 8'h11);
        send(0, 8'h22);
        send(0, 8'h33);
        send(0, 8'h44);
        chk_rsp(0, 0, 0, 0, 8'h00);
        chk("md_4", o_mru_data, 32'h11223344);
        send(0, 8'h22);
        chk_rsp(0, 1, 2, 0, 8'h00);
        chk("md_hit2", o_mru_data, 32'h11334422);
        send(0, 8'h22);
        chk_rsp(0, 1, 0, 0, 8'h00);
        chk("md_hit0", o_mru_data, 32'h11334422);

        do_reset();
        bus.req_data = 32'hA3A2A1A0;
        bus.req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("rr_grant", 32'(bus.req_ready), 32'(1 << (c % 4)));
            if (c > 0) begin
                chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("rr_rsp_id", 32'(bus.rsp_id), 32'((c - 1) % 4));
            end
            cyc();
        end
        bus.req_valid = '0;
        chk_rsp(0, 1, 3, 0, 8'h00);
        chk("md_rr", o_mru_data, 32'hA1A2A3A0);

        bus.req_valid = 4'b0010;
        i_flush = 1'b1;
        #1;
        chk("flush_block", 32'(bus.req_ready), 32'd0);
        chk("flush_busy0", 32'(o_busy), 32'd0);
        cyc();
        for (int j = 1; j <= 4; j++) begin
            i_flush = (j == 2);
            #1;
            chk("fl_ready", 32'(bus.req_ready), 32'd0);
            chk("fl_busy", 32'(o_busy), 32'd1);
            chk("fl_done", 32'(o_flush_done), 32'(j == 4));
            chk("fl_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("fl_valid", 32'(o_mru_valid), 32'(4'hF >> (j - 1)));
            cyc();
        end
        i_flush = 1'b0;
        #1;
        chk("post_ready", 32'(bus.req_ready), 32'h2);
        chk("post_busy", 32'(o_busy), 32'd0);
        chk("post_done", 32'(o_flush_done), 32'd0);
        chk("post_valid", 32'(o_mru_valid), 32'd0);
        chk("post_data", o_mru_data, 32'd0);
        cyc();
        bus.req_valid = '0;
        chk_rsp(1, 0, 0, 0, 8'h00);

        i_flush = 1'b1;
        cyc();
        i_flush = 1'b0;
        cyc();
        chk("abort_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_state", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_flush_done), 32'd0);
        chk("abort_valid", 32'(o_mru_valid), 32'd0);
        bus.req_valid = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("abort_grant", 32'(bus.req_ready), 32'(1 << c));
            chk("abort_nodone", 32'(o_flush_done), 32'd0);
            cyc();
        end
        bus.req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mru_share_arbiter.md
Name: mru_share_arbiter

Overview:
- Shares one 4-entry "last unique values" tracker between NUM_REQ byte-stream requesters.
- Selects one requester per cycle by round-robin and applies its byte to the tracker:
  - hit: move the entry to the front;
  - miss: insert at the front and evict the oldest entry.
- Returns a registered hit/miss response tagged with the requester id.
- Provides a sequenced multi-cycle flush. Sits between the stream sources and downstream consumers of the unique-value list.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data width of each entry.
- DEPTH, 4, number of tracker entries (2..8).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*DATA_W  requester i's byte at bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; combinational.
- flush  in  1  start a flush (single-cycle pulse or level).
- flush_done  out  1  one-cycle pulse when the flush completes.
- rsp_valid  out  1  response strobe, one cycle.
- rsp_id  out  $clog2(NUM_REQ)  requester that was served.
- rsp_hit  out  1  1 = data was already present.
- rsp_pos  out  $clog2(DEPTH)  pre-update hit position; 0 on a miss.
- rsp_evict_valid  out  1  a valid entry was pushed out.
- rsp_evict_data  out  DATA_W  the evicted value.
- mru_data  out  DEPTH*DATA_W  entry k at [k*DATA_W +: DATA_W]; entry 0 is the most recent.
- mru_valid  out  DEPTH  per-entry valid.
- busy  out  1  high while in FLUSH.

Behaviour:
- FSM states: RUN, FLUSH.
  - RUN->FLUSH when flush=1.
  - FLUSH->RUN after DEPTH cycles; flush_done pulses on the last FLUSH cycle.
- Reset values:
  - state = RUN;
  - all mru_data = 0, mru_valid = 0;
  - rr_ptr = NUM_REQ-1, so requester 0 wins first;
  - rsp_* = 0, flush_done = 0, busy = 0.
- Reset mid-flush aborts the flush immediately with no flush_done.
- Grant rule:
  - req_ready is nonzero only in RUN with flush=0.
  - Search starts at (rr_ptr+1) mod NUM_REQ; the first requester with req_valid=1 gets ready=1.
  - Acceptance = valid & ready. rr_ptr updates to the granted id on acceptance only.
- Flush priority: flush=1 in RUN blocks all grants that cycle; nothing is accepted.
- Throughput and latency: one acceptance per cycle. The tracker updates on the accepting edge; rsp_* is registered and valid on the next cycle for exactly one cycle.
- Back-to-back requests see the already-updated list.
- Compare rule: only entries with mru_valid=1 participate, so data 0 never hits an empty slot.
- Hit at p>0:
  - new[0] = old[p], new[1..p] = old[0..p-1], entries above p unchanged.
  - rsp_hit = 1, rsp_pos = p.
- Hit at p=0: list unchanged, rsp_hit = 1, rsp_pos = 0.
- Miss:
  - new[0] = data, new[k] = old[k-1], valid shifts likewise with valid[0] = 1.
  - rsp_evict_valid = old valid[DEPTH-1], rsp_evict_data = old[DEPTH-1]; 0 if not valid.
- FLUSH sequencing: a down-counter clears one entry per cycle, entry DEPTH-1 down to entry 0 (valid = 0, data = 0).
  - mru_* outputs reflect partial clearing.
  - No responses issue during FLUSH; a flush input seen while in FLUSH is ignored.
- A response pending from the acceptance cycle before flush still issues normally.
- Invariant: valid entries are contiguous from entry 0, and valid entries are pairwise distinct.

Decomposition:
- Shared package:
  - FSM state enum (RUN, FLUSH);
  - DATA_W default, DEPTH default;
  - a response struct {id, hit, pos, evict_valid, evict_data}.
- Sub-module mru_list_core owns the storage, valid bits, compare, move-to-front/insert/evict and per-entry clear. Its ports are: update strobe, data, clear strobe, clear index, hit/pos/evict outputs.
- The top holds the round-robin arbiter, the FSM and flush counter, and the response registers.

Test Plan:
- Reset, then req0 sends 0x00 -> rsp_valid next cycle with rsp_id=0, rsp_hit=0, rsp_pos=0, mru_valid=0001, entry0=0x00.
- req0 sends 0x11, 0x22, 0x33, 0x44, then 0x55:
  - the fifth response has rsp_evict_valid=1, rsp_evict_data=0x11;
  - list afterwards is 0x55, 0x44, 0x33, 0x22.
- With list 0x44, 0x33, 0x22, 0x11, send 0x22:
  - rsp_hit=1, rsp_pos=2;
  - list becomes 0x22, 0x44, 0x33, 0x11, no eviction.
- All four req_valid held high after reset:
  - grants go 0, 1, 2, 3, 0 on consecutive cycles;
  - rsp_id follows one cycle later.
- flush pulsed while req1 is valid:
  - req_ready=0 that cycle and for 4 FLUSH cycles, busy=1;
  - flush_done pulses on the 4th FLUSH cycle, then mru_valid=0000;
  - req1 is granted the next cycle.
- rst asserted in the 2nd FLUSH cycle: next cycle state=RUN, flush_done never pulses, mru_valid=0000, req0 wins first.
